e_mdu: RTL
==========

Name: e_mdu

Overview:
- Multi-cycle multiply/divide unit in the E stage, alongside E_ALU.
- Consumes the same forwarded A/B operands that E_ALU receives.
- Owns the architectural HI/LO registers and serves MFHI/MFLO/MTHI/MTLO.
- Drives a busy flag that the hazard unit uses to stall D when an MDU-class instruction follows an in-flight operation.

Parameters:
- MULT_CYCLES, 5, cycles busy stays high for MULT/MULTU (min 1).
- DIV_CYCLES, 10, cycles busy stays high for DIV/DIVU (min 1).

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset.
- A  in  32  forwarded rs operand.
- B  in  32  forwarded rt operand.
- E_MDUOp  in  3  operation code: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI/MFLO read (select via E_HILOSel).
- E_HILOSel  in  1  read select: 0 = LO, 1 = HI.
- E_start  in  1  E-stage instruction is valid and not flushed; qualifies E_MDUOp.
- E_busy  out  1  operation in flight.
- E_HILO  out  32  combinational read of HI or LO, per E_HILOSel.
- E_HI  out  32  HI register.
- E_LO  out  32  LO register.

Behaviour:
- Reset (reset==0, async): HI=0, LO=0, E_busy=0, cycle counter=0, latched operands/op cleared. Any in-flight operation is aborted with no commit.
- States:
  - IDLE: E_busy=0.
  - RUN: E_busy=1, counter counts down.
- IDLE -> RUN: at a rising edge with E_start=1 and E_MDUOp in {MULT, MULTU, DIV, DIVU}.
  - Latch A, B and op.
  - Load counter with MULT_CYCLES-1 or DIV_CYCLES-1.
  - Compute the 64-bit result now or iteratively; internal method is free.
- RUN: counter decrements each edge. At the edge where counter==0: commit result, return to IDLE.
  - E_busy is therefore high for exactly N consecutive cycles after the start edge (N = MULT_CYCLES or DIV_CYCLES).
  - The commit edge is the first edge with E_busy low afterwards... precisely: the new HI/LO is visible in the cycle E_busy first reads 0.
- Arithmetic:
  - MULT: {HI,LO} = signed(A)*signed(B), full 64 bits.
  - MULTU: {HI,LO} = unsigned(A)*unsigned(B).
  - DIV: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend (A).
  - DIVU: same, unsigned.
  - Overflow case DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000.
  - Divide by zero (B==0) for DIV/DIVU: busy sequence runs normally for DIV_CYCLES, but HI/LO are left unchanged at commit.
- MTHI/MTLO: with E_start=1 and E_busy=0, HI (resp. LO) <= A at the edge; no busy.
- Reads: E_HILO is purely combinational from the current HI/LO.
  - During RUN it returns the old values.
  - The hazard unit must stall MFHI/MFLO while E_busy | start-of-mult/div; this block does not stall.
- E_start=1 with any op while E_busy=1 is ignored: no latch, no HI/LO write. The hazard unit guarantees this does not happen; the block must still be robust to it.
- E_start=0 or E_MDUOp=NONE/read: no state change.
- Counter width = clog2(max(MULT_CYCLES, DIV_CYCLES)), minimum 1 bit. No wrap: the counter never decrements below 0.
- Back-to-back: a new start is accepted at the edge immediately following the commit edge (the first cycle E_busy=0).

Test Plan:
- Reset mid-op:
  - Stimulus: MULT start, then reset=0 on cycle 2.
  - Required: E_busy=0 immediately (async), HI=LO=0. No commit after reset releases.
- MULT signed:
  - Stimulus: MULT with A=0xFFFFFFFE (-2), B=3.
  - Required: E_busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU:
  - Stimulus: MULTU with A=B=0xFFFFFFFF.
  - Required: HI=0xFFFFFFFE, LO=0x00000001 after 5 busy cycles.
- DIV signed and overflow:
  - Stimulus: DIV with A=-7, B=2.
  - Required: LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 busy cycles.
  - Stimulus: DIV with A=0x80000000, B=0xFFFFFFFF.
  - Required: LO=0x80000000, HI=0.
- DIVU by zero:
  - Stimulus: preload HI=0x1234 and LO=0x5678 via MTHI/MTLO, then DIVU with B=0.
  - Required: 10 busy cycles, then HI/LO still 0x1234/0x5678.
- Start while busy plus back-to-back:
  - Stimulus: MTLO A=0xDEAD issued during MULT RUN.
  - Required: ignored; LO = product at commit.
  - Stimulus: a second MULT on the first idle cycle.
  - Required: accepted; E_busy deasserts for exactly one cycle between the two operations.

Source files
------------

// File: rtl/e_mdu.sv
`default_nettype none
// ============================================================================
// Module      : e_mdu
// Description : E-stage multi-cycle multiply/divide unit owning HI/LO.
// Revision    : 1.0
// ============================================================================
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  E_MDUOp,
    input  logic        E_HILOSel,
    input  logic        E_start,
    output logic        E_busy,
    output logic [31:0] E_HILO,
    output logic [31:0] E_HI,
    output logic [31:0] E_LO
);

    localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W      = (c_MAX_CYCLES > 1) ? $clog2(c_MAX_CYCLES) : 1;

    localparam logic [c_CNT_W-1:0] c_MULT_LOAD = c_CNT_W'(MULT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD  = c_CNT_W'(DIV_CYCLES - 1);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    localparam logic [2:0] c_OP_MULT  = 3'd1;
    localparam logic [2:0] c_OP_MULTU = 3'd2;
    localparam logic [2:0] c_OP_DIV   = 3'd3;
    localparam logic [2:0] c_OP_DIVU  = 3'd4;
    localparam logic [2:0] c_OP_MTHI  = 3'd5;
    localparam logic [2:0] c_OP_MTLO  = 3'd6;

    logic [0:0]         state_q, state_d;
    logic [c_CNT_W-1:0] cnt_q,   cnt_d;
    logic [31:0]        a_q,     a_d;
    logic [31:0]        b_q,     b_d;
    logic [2:0]         op_q,    op_d;
    logic [31:0]        hi_q,    hi_d;
    logic [31:0]        lo_q,    lo_d;

    // Operands are sign/zero extended to 64 bits, so a plain product gives the full result.
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    assign w_prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    assign w_prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Signed divide works on magnitudes; 0x80000000/-1 falls out as 0x80000000 rem 0.
    logic        w_neg_a, w_neg_b;
    logic [31:0] w_mag_a, w_mag_b, w_divisor;
    logic [31:0] w_quo_mag, w_rem_mag, w_quo, w_rem;
    assign w_neg_a   = (op_q == c_OP_DIV) & a_q[31];
    assign w_neg_b   = (op_q == c_OP_DIV) & b_q[31];
    assign w_mag_a   = w_neg_a ? -a_q : a_q;
    assign w_mag_b   = w_neg_b ? -b_q : b_q;
    assign w_divisor = (w_mag_b == 32'd0) ? 32'd1 : w_mag_b;
    assign w_quo_mag = w_mag_a / w_divisor;
    assign w_rem_mag = w_mag_a % w_divisor;
    assign w_quo     = (w_neg_a ^ w_neg_b) ? -w_quo_mag : w_quo_mag;
    assign w_rem     = w_neg_a ? -w_rem_mag : w_rem_mag;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            c_ST_IDLE: begin
                if (E_start) begin
                    case (E_MDUOp)
                        c_OP_MULT, c_OP_MULTU, c_OP_DIV, c_OP_DIVU: begin
                            state_d = c_ST_RUN;
                            cnt_d   = (E_MDUOp == c_OP_MULT || E_MDUOp == c_OP_MULTU)
                                      ? c_MULT_LOAD : c_DIV_LOAD;
                            a_d     = A;
                            b_d     = B;
                            op_d    = E_MDUOp;
                        end
                        c_OP_MTHI: hi_d = A;
                        c_OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            c_ST_RUN: begin
                if (cnt_q == '0) begin
                    state_d = c_ST_IDLE;
                    case (op_q)
                        c_OP_MULT:  {hi_d, lo_d} = w_prod_s;
                        c_OP_MULTU: {hi_d, lo_d} = w_prod_u;
                        c_OP_DIV, c_OP_DIVU: begin
                            if (b_q != 32'd0) begin
                                hi_d = w_rem;
                                lo_d = w_quo;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= c_ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign E_busy = (state_q == c_ST_RUN);
    assign E_HI   = hi_q;
    assign E_LO   = lo_q;
    assign E_HILO = E_HILOSel ? hi_q : lo_q;

endmodule
`default_nettype wire
